// File: rtl/control_unit.sv
// K&S processor sequencing FSM: FETCH -> DECODE -> execute state; HALT parks the core until rst.
// Optional feature: define INSTR_COUNT_EN to add the instr_count[15:0] retired-instruction counter.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]             instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ALU, S_MOVE, S_BR, S_HALT
  } state_t;

  state_t     state_q;
  logic [3:0] wait_cnt_q;
  logic [1:0] op_q;
  state_t     dec_state;
  logic [1:0] dec_op;
  logic       wait_done;
  logic       br_taken;
  logic       unused_uovf;

  assign unused_uovf = unsigned_overflow;
  assign wait_done   = (wait_cnt_q == 4'(MEM_WAIT_CYCLES));

  always_comb begin
    dec_state = S_FETCH;
    dec_op    = 2'b00;
    case (decoded_instruction)
      I_LOAD:  dec_state = S_LOAD;
      I_STORE: dec_state = S_STORE;
      I_MOVE:  dec_state = S_MOVE;
      I_ADD:   begin dec_state = S_ALU; dec_op = 2'b01; end
      I_SUB:   begin dec_state = S_ALU; dec_op = 2'b10; end
      I_AND:   begin dec_state = S_ALU; dec_op = 2'b11; end
      I_OR:    begin dec_state = S_ALU; dec_op = 2'b00; end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
      I_BNNEG, I_BOV, I_BNOV:  dec_state = S_BR;
      I_HALT:  dec_state = S_HALT;
      default: dec_state = S_FETCH;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (decoded_instruction)
      I_BRANCH: br_taken = 1'b1;
      I_BZERO:  br_taken = zero_op;
      I_BNZERO: br_taken = ~zero_op;
      I_BNEG:   br_taken = neg_op;
      I_BNNEG:  br_taken = ~neg_op;
      I_BOV:    br_taken = signed_overflow;
      I_BNOV:   br_taken = ~signed_overflow;
      default:  br_taken = 1'b0;
    endcase
  end

  // ALU opcode is latched in DECODE so the enum need not stay valid during ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      op_q       <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (wait_done) begin
            state_q    <= S_DECODE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_DECODE: begin
          state_q    <= dec_state;
          op_q       <= dec_op;
          wait_cnt_q <= '0;
        end
        S_LOAD: begin
          if (wait_done) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_STORE, S_ALU, S_MOVE, S_BR: begin
          state_q    <= S_FETCH;
          wait_cnt_q <= '0;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_enable = wait_done;
        pc_enable = wait_done;
      end
      S_LOAD: begin
        addr_sel         = 1'b1;
        write_reg_enable = wait_done;
      end
      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_ALU: begin
        operation        = op_q;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
      end
      S_MOVE: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_BR: begin
        branch    = br_taken;
        pc_enable = br_taken;
      end
      S_HALT:  halt = 1'b1;
      default: halt = 1'b0;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] icnt_q;
  logic        retire;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_DECODE:                     retire = (dec_state == S_FETCH);
      S_LOAD:                       retire = wait_done;
      S_STORE, S_ALU, S_MOVE, S_BR: retire = 1'b1;
      default:                      retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         icnt_q <= '0;
    else if (retire) icnt_q <= icnt_q + 16'd1;
  end

  assign instr_count = icnt_q;
`endif

  a_one_strobe: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ir_enable, write_reg_enable, ram_write_enable}));

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (MEM_WAIT_CYCLES 1 and 2) run the same instruction program
// against a per-instruction expected-output trace built from the sequencing rules.
module tb_control_unit;
  import k_and_s_pkg::*;

  typedef logic [10:0] vec_t;
  typedef vec_t vq_t[$];

  // Output vector bit positions: {branch,pc,ir,addr,c_sel,op[1:0],wre,fre,rwe,halt}
  localparam vec_t V_BR  = 11'h400;
  localparam vec_t V_PC  = 11'h200;
  localparam vec_t V_IR  = 11'h100;
  localparam vec_t V_AS  = 11'h080;
  localparam vec_t V_CS  = 11'h040;
  localparam vec_t V_WRE = 11'h008;
  localparam vec_t V_FRE = 11'h004;
  localparam vec_t V_RWE = 11'h002;
  localparam vec_t V_HLT = 11'h001;

  localparam int unsigned WS [2] = '{1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst [2];
  decoded_instruction_type di  [2];
  logic                    zf [2], nf [2], uf [2], vf [2];
  vec_t                    out [2];
`ifdef INSTR_COUNT_EN
  logic [15:0]             icnt [2];
  int                      mcnt [2];
`endif

  int   total = 0;
  int   bad   = 0;
  vec_t expq [2][$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0] operation;
    logic       write_reg_enable, flags_reg_enable, ram_write_enable, halt;

    control_unit #(.MEM_WAIT_CYCLES(WS[g])) u_dut (
      .clk                 (clk),
      .rst                 (rst[g]),
      .decoded_instruction (di[g]),
      .zero_op             (zf[g]),
      .neg_op              (nf[g]),
      .unsigned_overflow   (uf[g]),
      .signed_overflow     (vf[g]),
      .branch              (branch),
      .pc_enable           (pc_enable),
      .ir_enable           (ir_enable),
      .addr_sel            (addr_sel),
      .c_sel               (c_sel),
      .operation           (operation),
      .write_reg_enable    (write_reg_enable),
      .flags_reg_enable    (flags_reg_enable),
      .ram_write_enable    (ram_write_enable),
      .halt                (halt)
`ifdef INSTR_COUNT_EN
      ,
      .instr_count         (icnt[g])
`endif
    );

    assign out[g] = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                     write_reg_enable, flags_reg_enable, ram_write_enable, halt};
  end

  // Cycle-by-cycle outputs one instruction must produce, starting from its first FETCH cycle.
  function automatic vq_t expect_seq(input int unsigned w, input decoded_instruction_type ins,
                                     input logic z, input logic n, input logic v);
    vq_t  q;
    logic taken;
    for (int unsigned i = 0; i < w; i++) q.push_back('0);
    q.push_back(V_PC | V_IR);
    q.push_back('0);
    taken = 1'b0;
    case (ins)
      I_LOAD: begin
        for (int unsigned i = 0; i < w; i++) q.push_back(V_AS);
        q.push_back(V_AS | V_WRE);
      end
      I_STORE: q.push_back(V_AS | V_RWE);
      I_MOVE:  q.push_back(V_CS | V_WRE);
      I_ADD:   q.push_back(V_CS | V_WRE | V_FRE | 11'h010);
      I_SUB:   q.push_back(V_CS | V_WRE | V_FRE | 11'h020);
      I_AND:   q.push_back(V_CS | V_WRE | V_FRE | 11'h030);
      I_OR:    q.push_back(V_CS | V_WRE | V_FRE);
      I_HALT:  for (int i = 0; i < 20; i++) q.push_back(V_HLT);
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        if      (ins == I_BRANCH) taken = 1'b1;
        else if (ins == I_BZERO)  taken = z;
        else if (ins == I_BNZERO) taken = !z;
        else if (ins == I_BNEG)   taken = n;
        else if (ins == I_BNNEG)  taken = !n;
        else if (ins == I_BOV)    taken = v;
        else                      taken = !v;
        q.push_back(taken ? (V_BR | V_PC) : vec_t'(0));
      end
      default: ;
    endcase
    return q;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (expq[d].size() > 0) begin
        vec_t e;
        e = expq[d].pop_front();
        total++;
        if (out[d] !== e) begin
          bad++;
          $display("FAIL dut%0d_outputs t=%0t got=%b exp=%b", d, $time, out[d], e);
        end
      end
    end
  end

  // Called at posedge+1 of an instruction's first FETCH cycle; rst_at>=0 raises rst in that cycle index.
  task automatic run_instr(input int d, input decoded_instruction_type ins,
                           input logic z, input logic n, input logic v, input int rst_at);
    vq_t q;
    q = expect_seq(WS[d], ins, z, n, v);
    if (rst_at >= 0)
      while (q.size() > rst_at + 1) void'(q.pop_back());
    di[d] = ins; zf[d] = z; nf[d] = n; vf[d] = v;
    uf[d] = 1'($urandom_range(0, 1));
    foreach (q[i]) expq[d].push_back(q[i]);
    for (int i = 0; i < q.size(); i++) begin
      if (i == rst_at) rst[d] = 1'b1;
      @(posedge clk); #1;
    end
    rst[d] = 1'b0;
`ifdef INSTR_COUNT_EN
    if (rst_at >= 0)        mcnt[d] = 0;
    else if (ins != I_HALT) mcnt[d] = (mcnt[d] + 1) % 65536;
    chk($sformatf("dut%0d_instr_count", d), int'(icnt[d]), mcnt[d]);
`endif
  endtask

  task automatic prog(input int d);
    run_instr(d, I_NOP,   1'b0, 1'b0, 1'b0, -1);
    run_instr(d, I_ADD,   1'b1, 1'b0, 1'b1, -1);
    run_instr(d, I_SUB,   1'b0, 1'b1, 1'b0, -1);
    run_instr(d, I_AND,   1'b0, 1'b0, 1'b0, -1);
    run_instr(d, I_OR,    1'b1, 1'b1, 1'b1, -1);
    run_instr(d, I_MOVE,  1'b0, 1'b0, 1'b0, -1);
    run_instr(d, I_LOAD,  1'b0, 1'b0, 1'b0, -1);
    run_instr(d, I_STORE, 1'b0, 1'b0, 1'b0, -1);
    run_instr(d, I_BRANCH, 1'b0, 1'b0, 1'b0, -1);
    for (int b = 0; b < 2; b++) begin
      run_instr(d, I_BZERO,  1'(b), 1'(~b), 1'(~b), -1);
      run_instr(d, I_BNZERO, 1'(b), 1'(~b), 1'(~b), -1);
      run_instr(d, I_BNEG,   1'(~b), 1'(b), 1'(~b), -1);
      run_instr(d, I_BNNEG,  1'(~b), 1'(b), 1'(~b), -1);
      run_instr(d, I_BOV,    1'(~b), 1'(~b), 1'(b), -1);
      run_instr(d, I_BNOV,   1'(~b), 1'(~b), 1'(b), -1);
    end
    run_instr(d, I_LOAD,  1'b0, 1'b0, 1'b0, int'(WS[d]) + 2);
    run_instr(d, I_NOP,   1'b0, 1'b0, 1'b0, -1);
    run_instr(d, I_HALT,  1'b0, 1'b0, 1'b0, int'(WS[d]) + 21);
    run_instr(d, I_ADD,   1'b0, 1'b0, 1'b0, -1);
    run_instr(d, I_STORE, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    vq_t q;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; di[d] = I_NOP; zf[d] = 1'b0; nf[d] = 1'b0; uf[d] = 1'b0; vf[d] = 1'b0;
`ifdef INSTR_COUNT_EN
      mcnt[d] = 0;
`endif
    end

    q = expect_seq(1, I_ADD, 1'b0, 1'b0, 1'b0);
    chk("model_add_len_w1", q.size(), 4);
    chk("model_fetch_strobe", int'(q[1]), 'h300);
    chk("model_add_exec", int'(q[3]), 'h05C);
    q = expect_seq(2, I_LOAD, 1'b0, 1'b0, 1'b0);
    chk("model_load_len_w2", q.size(), 7);
    chk("model_load_last", int'(q[6]), 'h088);
    q = expect_seq(1, I_BZERO, 1'b1, 1'b0, 1'b0);
    chk("model_bzero_taken", int'(q[3]), 'h600);
    q = expect_seq(1, I_HALT, 1'b0, 1'b0, 1'b0);
    chk("model_halt_len", q.size(), 23);

    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    fork
      prog(0);
      prog(1);
    join

    @(negedge clk); #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("dut%0d_trace_drained", d), expq[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
